// File: rtl/router_pkg.sv
// Shared router definitions: flit width, buffer depth
// and the port index order N/E/W/S/L.
package router_pkg;

    localparam int FLIT_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int NPORTS     = 5;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_W = 2;
    localparam int PORT_S = 3;
    localparam int PORT_L = 4;

endpackage

// File: rtl/fifo_input_buffer.sv
// Per-port router input buffer: RTS/CTS write side,
// grant-driven dequeue, head flit presented to the crossbar.
module fifo_input_buffer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RX,
    input  logic                  DRTS,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic                  CTS,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] Data_out
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  cts_q, cts_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic wr, rd, any_rd;

    assign any_rd = read_en_N | read_en_E | read_en_W
                  | read_en_S | read_en_L;

    // Flags come from the registered count only, so a
    // read never opens a slot for a same-cycle write.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    // CTS_reg blocks back-to-back acceptance, making CTS
    // a one-cycle pulse per accepted flit.
    assign wr = DRTS & ~cts_q & ~full;
    assign rd = any_rd & ~empty;

    assign CTS      = cts_q;
    assign Data_out = mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and handshake flop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cts_d    = wr;
        if (wr) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr && !rd) count_d = count_q + (PW+1)'(1);
        if (rd && !wr) count_d = count_q - (PW+1)'(1);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cts_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cts_q    <= cts_d;
        end
    end

    // Flit storage; cleared on reset so Data_out reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr) begin
            mem_q[wr_ptr_q] <= RX;
        end
    end

endmodule

// File: tb/tb_fifo_input_buffer.sv
// Scoreboard bench for fifo_input_buffer: flits queued on
// issue, checked in order by a dequeue monitor.
module tb_fifo_input_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RX;
    logic        DRTS;
    logic        rN, rE, rW, rS, rL;
    logic        CTS, empty, full;
    logic [31:0] Data_out;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb [$];

    fifo_input_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .DRTS     (DRTS),
        .read_en_N(rN),
        .read_en_E(rE),
        .read_en_W(rW),
        .read_en_S(rS),
        .read_en_L(rL),
        .CTS      (CTS),
        .empty    (empty),
        .full     (full),
        .Data_out (Data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream arbiter model: hold RTS until CTS is seen.
    task automatic send(input logic [31:0] d);
        bit got;
        got = 0;
        sb.push_back(d);
        RX   = d;
        DRTS = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (CTS) got = 1;
        end
        DRTS = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: no CTS for %h", d);
        end
    endtask

    task automatic rd(input int p);
        rN = (p == 0); rE = (p == 1); rW = (p == 2);
        rS = (p == 3); rL = (p == 4);
        tick();
        {rN, rE, rW, rS, rL} = '0;
    endtask

    // Monitor: every accepted dequeue must show the oldest flit.
    always @(negedge clk) begin
        if (!rst && (rN | rE | rW | rS | rL) && !empty) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underrun: got %h expected none",
                         Data_out);
            end else begin
                chk("sb_order", Data_out, sb.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        {rN, rE, rW, rS, rL} = '0;
        RX   = 32'hDEAD_BEEF;
        DRTS = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_cts", {31'b0, CTS}, 0);
        chk("rst_empty", {31'b0, empty}, 1);
        chk("rst_full", {31'b0, full}, 0);
        chk("rst_dout", Data_out, 0);
        DRTS = 1'b0;
        tick();

        // Single flit, one-cycle CTS pulse
        send(32'hA5A5_0001);
        chk("single_dout", Data_out, 32'hA5A5_0001);
        chk("single_empty", {31'b0, empty}, 0);
        tick();
        chk("single_cts_pulse", {31'b0, CTS}, 0);
        rd(1);
        chk("single_drain", {31'b0, empty}, 1);

        // Fill to full, fifth flit held off
        for (int i = 1; i <= 4; i++) send(i);
        chk("fill_full", {31'b0, full}, 1);
        sb.push_back(32'h5);
        RX   = 32'h5;
        DRTS = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_no_cts", {31'b0, CTS}, 0);
        end
        rd(0);
        chk("full_rd_no_cts", {31'b0, CTS}, 0);
        chk("full_after_rd", {31'b0, full}, 0);
        tick();
        chk("fifth_cts", {31'b0, CTS}, 1);
        chk("refull", {31'b0, full}, 1);
        DRTS = 1'b0;
        for (int i = 0; i < 4; i++) rd(3);
        chk("fill_drain", {31'b0, empty}, 1);

        // Wrap-around with interleaved reads
        send(32'h10);
        send(32'h11);
        for (int i = 2; i < 10; i++) begin
            send(32'h10 + i);
            chk("wrap_not_full", {31'b0, full}, 0);
            rd(i % 5);
        end
        rd(2);
        rd(4);
        chk("wrap_drain", {31'b0, empty}, 1);

        // Simultaneous read and write at count 2
        send(32'hB0);
        send(32'hB1);
        tick();
        sb.push_back(32'hB2);
        RX   = 32'hB2;
        DRTS = 1'b1;
        rW   = 1'b1;
        tick();
        DRTS = 1'b0;
        rW   = 1'b0;
        chk("rw_cts", {31'b0, CTS}, 1);
        chk("rw_head", Data_out, 32'hB1);
        rd(0);
        chk("rw_cnt2", {31'b0, empty}, 0);
        rd(0);
        chk("rw_cnt_drain", {31'b0, empty}, 1);

        // Multi-grant counts as one dequeue
        send(32'hC0);
        send(32'hC1);
        send(32'hC2);
        rN = 1'b1;
        rS = 1'b1;
        tick();
        rN = 1'b0;
        rS = 1'b0;
        chk("multi_head", Data_out, 32'hC1);
        rd(1);
        chk("multi_cnt1", {31'b0, empty}, 0);
        rd(1);
        chk("multi_cnt0", {31'b0, empty}, 1);

        // Read on empty is ignored
        held = Data_out;
        rd(4);
        chk("empty_rd_empty", {31'b0, empty}, 1);
        chk("empty_rd_dout", Data_out, held);
        send(32'hD0);
        chk("empty_rd_next", Data_out, 32'hD0);
        rd(4);

        // Reset mid-transfer drops stored flits
        send(32'hE0);
        send(32'hE1);
        RX   = 32'hE2;
        DRTS = 1'b1;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        DRTS = 1'b0;
        sb.delete();
        chk("mid_rst_cts", {31'b0, CTS}, 0);
        chk("mid_rst_empty", {31'b0, empty}, 1);
        chk("mid_rst_dout", Data_out, 0);
        tick();
        chk("mid_rst_cts2", {31'b0, CTS}, 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
